// File: rtl/timer_dev.sv
// timer_dev: memory-mapped interval timer (TCNT/TLIM/TCTL) with prescaler, sticky Ready/Overrun and irq
module timer_dev #(
  parameter int DBITS = 32,
  parameter int CLKDIV = 50000,
  parameter logic [DBITS-1:0] ADDRTCNT = 32'hFFFFF100,
  parameter logic [DBITS-1:0] ADDRTLIM = 32'hFFFFF104,
  parameter logic [DBITS-1:0] ADDRTCTL = 32'hFFFFF108
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [DBITS-1:0] addr,
  input  logic             wr_en,
  input  logic [DBITS-1:0] wr_data,
  output logic [DBITS-1:0] rd_data,
  output logic             sel,
  output logic             irq
);
  localparam logic [19:0] PMAX = 20'(CLKDIV - 1);
  logic [DBITS-1:0] tcnt, tlim, ctl;
  logic [19:0] pre;
  logic rdy, ovr, ie;
  logic hit_cnt, hit_lim, hit_ctl, we_cnt, we_lim, we_ctl;
  logic pre_end, tick, wrap, clr_rdy, clr_ovr;
  always_comb begin
    hit_cnt = addr == ADDRTCNT;
    hit_lim = addr == ADDRTLIM;
    hit_ctl = addr == ADDRTCTL;
    we_cnt = wr_en & hit_cnt;
    we_lim = wr_en & hit_lim;
    we_ctl = wr_en & hit_ctl;
    pre_end = pre == PMAX;
    tick = pre_end & ~we_cnt & ~we_lim;
    wrap = tick & (tlim != '0) & (tcnt == tlim - DBITS'(1));
    clr_rdy = we_ctl & ~wr_data[0];
    clr_ovr = we_ctl & ~wr_data[2];
    ctl = '0;
    ctl[0] = rdy;
    ctl[2] = ovr;
    ctl[8] = ie;
    sel = hit_cnt | hit_lim | hit_ctl;
    rd_data = hit_cnt ? tcnt : hit_lim ? tlim : hit_ctl ? ctl : '0;
  end
  assign irq = rdy & ie;
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      pre <= '0;
      tcnt <= '0;
      tlim <= '0;
      rdy <= 1'b0;
      ovr <= 1'b0;
      ie <= 1'b0;
    end else begin
      pre <= (pre_end | we_cnt | we_lim) ? '0 : pre + 20'd1;
      tcnt <= we_lim ? '0 : we_cnt ? wr_data : wrap ? '0 : tick ? tcnt + DBITS'(1) : tcnt;
      if (we_lim) tlim <= wr_data;
      // a wrap outranks a same-cycle clear, and a clear of Ready acknowledges the prior event
      rdy <= wrap | (rdy & ~clr_rdy);
      ovr <= (wrap & rdy & ~clr_rdy) | (ovr & ~clr_ovr);
      if (we_ctl) ie <= wr_data[8];
    end
endmodule

// File: tb/tb_timer_dev.sv
// tb_timer_dev: scoreboard bench for timer_dev, one instance with CLKDIV=4 and one with CLKDIV=1
module tb_timer_dev;
  localparam logic [31:0] A_CNT = 32'hFFFFF100;
  localparam logic [31:0] A_LIM = 32'hFFFFF104;
  localparam logic [31:0] A_CTL = 32'hFFFFF108;
  localparam logic [31:0] A_BAD = 32'hFFFFF10C;

  typedef struct {
    logic [31:0] d;
    logic s;
    logic i;
    string n;
  } exp_t;

  logic clk = 0, reset4 = 1, reset1 = 1, wr_en = 0, chk = 0, which = 0;
  logic [31:0] addr = '0, wr_data = '0, rd4, rd1, md;
  logic sel4, sel1, irq4, irq1, ms, mi;
  exp_t q[$];
  int checks = 0, errors = 0;

  always #5 clk = ~clk;

  timer_dev #(.CLKDIV(4)) u4 (.clk(clk), .reset(reset4), .addr(addr), .wr_en(wr_en),
    .wr_data(wr_data), .rd_data(rd4), .sel(sel4), .irq(irq4));
  timer_dev #(.CLKDIV(1)) u1 (.clk(clk), .reset(reset1), .addr(addr), .wr_en(wr_en),
    .wr_data(wr_data), .rd_data(rd1), .sel(sel1), .irq(irq1));

  assign md = which ? rd1 : rd4;
  assign ms = which ? sel1 : sel4;
  assign mi = which ? irq1 : irq4;

  always @(negedge clk)
    if (chk) begin
      exp_t e;
      checks++;
      if (q.size() == 0) begin
        errors++;
        $display("FAIL scoreboard: read with no expected entry");
      end else begin
        e = q.pop_front();
        if (md !== e.d || ms !== e.s || mi !== e.i) begin
          errors++;
          $display("FAIL %s: got rd_data=%h sel=%b irq=%b, required rd_data=%h sel=%b irq=%b",
                   e.n, md, ms, mi, e.d, e.s, e.i);
        end
      end
    end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    addr = a;
    wr_data = d;
    wr_en = 1;
    step();
    wr_en = 0;
  endtask

  task automatic rd(input logic [31:0] a, input logic [31:0] d, input logic s, input logic i,
                    input string n);
    exp_t e;
    e.d = d;
    e.s = s;
    e.i = i;
    e.n = n;
    q.push_back(e);
    addr = a;
    chk = 1;
    step();
    chk = 0;
  endtask

  initial begin
    repeat (2) step();
    reset4 = 0;
    rd(A_CNT, 32'h0, 1, 0, "reset_tcnt");
    rd(A_CTL, 32'h0, 1, 0, "reset_tctl");
    rd(A_LIM, 32'h0, 1, 0, "reset_tlim");
    repeat (17) step();
    rd(A_CNT, 32'd5, 1, 0, "free_run_20cyc");
    rd(A_CTL, 32'h0, 1, 0, "free_run_tctl");

    wr(A_LIM, 32'd3);
    wr(A_CTL, 32'h100);
    repeat (3) step();
    rd(A_CNT, 32'd1, 1, 0, "tick1");
    repeat (3) step();
    rd(A_CNT, 32'd2, 1, 0, "tick2");
    repeat (3) step();
    rd(A_CNT, 32'd0, 1, 1, "wrap_tcnt");
    rd(A_CTL, 32'h101, 1, 1, "wrap_ready");
    repeat (10) step();
    rd(A_CTL, 32'h105, 1, 1, "overrun");
    wr(A_CTL, 32'h100);
    rd(A_CTL, 32'h100, 1, 0, "clear_flags");
    rd(A_CNT, 32'd0, 1, 0, "tcnt_after_clear");
    wr(A_BAD, 32'd7);
    wr(32'hFFFFF105, 32'd7);
    rd(A_LIM, 32'd3, 1, 0, "nonmatch_write");
    rd(A_BAD, 32'h0, 0, 0, "bad_addr4");

    which = 1;
    reset1 = 0;
    wr(A_LIM, 32'd2);
    step();
    step();
    rd(A_CTL, 32'h001, 1, 0, "div1_ready");
    wr(A_CTL, 32'h000);
    rd(A_CTL, 32'h001, 1, 0, "clear_vs_wrap");
    step();
    rd(A_CTL, 32'h005, 1, 0, "div1_overrun");
    wr(A_CTL, 32'h001);
    rd(A_CTL, 32'h005, 1, 0, "clr_ovr_vs_wrap");

    wr(A_LIM, 32'h0);
    wr(A_CTL, 32'h0);
    wr(A_CNT, 32'hFFFFFFFE);
    rd(A_CNT, 32'hFFFFFFFE, 1, 0, "tcnt_write");
    rd(A_CNT, 32'hFFFFFFFF, 1, 0, "pre_rollover");
    rd(A_CNT, 32'h0, 1, 0, "rollover");
    rd(A_CTL, 32'h0, 1, 0, "rollover_noflags");

    wr(A_LIM, 32'd2);
    wr(A_CTL, 32'h100);
    step();
    rd(A_CTL, 32'h101, 1, 1, "irq_before_reset");
    reset1 = 1;
    rd(A_CTL, 32'h0, 1, 0, "async_reset_tctl");
    rd(A_CNT, 32'h0, 1, 0, "async_reset_tcnt");
    rd(A_LIM, 32'h0, 1, 0, "async_reset_tlim");
    reset1 = 0;
    rd(A_BAD, 32'h0, 0, 0, "bad_addr1");

    step();
    if (q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL scoreboard_drain: %0d entries left, required 0", q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/timer_dev.md
Name: timer_dev

Overview:
- Memory-mapped interval timer on the data bus consumed by the CPU's MEM stage, alongside the HEX, LEDR, KEY and SW devices.
- Provides three registers, TCNT, TLIM and TCTL, at fixed word addresses.
- A prescaler turns clk into a periodic tick; TCNT counts ticks, wraps at TLIM and sets a sticky Ready flag (and Overrun on a second unacknowledged wrap).
- Reads are combinational so the MEM stage can mux rd_data into its latch in the same cycle; irq = Ready & IE for a future interrupt stage.

Parameters:
DBITS, 32, data/address width
CLKDIV, 50000, clk cycles per tick (1 ms at 50 MHz); legal range 1..2^20
ADDRTCNT, 32'hFFFFF100, TCNT address
ADDRTLIM, 32'hFFFFF104, TLIM address
ADDRTCTL, 32'hFFFFF108, TCTL address

Ports:
clk  input  1  system clock (PLL output)
reset  input  1  asynchronous, active-high reset
addr  input  DBITS  MEM-stage byte address (aluout_EX)
wr_en  input  1  store in MEM stage this cycle
wr_data  input  DBITS  store data (regval2_EX)
rd_data  output  DBITS  combinational read data; 0 when sel=0
sel  output  1  combinational; 1 when addr equals one of the three register addresses
irq  output  1  registered-state derived: TCTL.Ready & TCTL.IE

Behaviour:
- Reset is asynchronous and active-high: TCNT=0, TLIM=0, prescaler=0, Ready=0, Overrun=0, IE=0, so irq=0. Reset mid-count discards all state immediately.
- Prescaler:
  - Counts 0..CLKDIV-1 each clk.
  - tick=1 in the cycle the prescaler equals CLKDIV-1; the prescaler returns to 0 on that edge.
  - CLKDIV=1 gives a tick every cycle.
- Counter on a tick:
  - If TLIM!=0 and TCNT==TLIM-1: TCNT<=0 (a "wrap"). If Ready is already 1, Overrun<=1; otherwise Ready<=1.
  - Otherwise: TCNT<=TCNT+1, mod 2^32.
  - TLIM=0 means free-running. A 32-bit rollover sets no flags.
- TCTL layout:
  - bit0 Ready, bit2 Overrun, bit8 IE; all other bits read 0.
  - Writes to Ready and Overrun: writing 0 clears, writing 1 has no effect.
  - IE is written directly.
- Writes take effect on the posedge where wr_en=1 and addr matches:
  - TCNT write: TCNT<=wr_data; prescaler<=0.
  - TLIM write: TLIM<=wr_data; TCNT<=0; prescaler<=0.
  - Any write that resets the prescaler suppresses a tick due in the same cycle; the write wins.
- Simultaneous events:
  - TCTL write clearing Ready in the same cycle as a wrap: Ready stays 1 and Overrun is unchanged, so the event is not lost.
  - TCTL write clearing Overrun in the same cycle as a wrap with Ready=1 (Ready not being cleared): Overrun stays 1.
- Reads: rd_data = TCNT, TLIM or TCTL image per addr; 0 for any other addr. Reads have no side effects.
- Addresses are full 32-bit compares with no aliasing. Byte offsets other than the listed words do not hit.
- wr_en with a non-matching addr changes nothing.
- Timing:
  - A value written on edge N is visible on rd_data in cycle N+1.
  - irq follows Ready/IE with zero additional latency after the flop update.

Test Plan:
- CLKDIV=4, reset released, no writes, 20 cycles -> TCNT reads 5 (ticks at cycles 3,7,11,15,19), Ready=0, irq=0.
- CLKDIV=4; write TLIM=3, TCTL=0x100 (IE=1) -> TCNT goes 0,1,2,0 on successive ticks; Ready=1 and irq=1 on the edge of the 3rd tick; TCTL reads 0x101.
- Continue without clearing Ready for 3 more ticks -> Overrun=1, TCTL reads 0x105. Then write TCTL=0x100 -> reads 0x100, irq=0.
- CLKDIV=1, TLIM=2, Ready=1: write TCTL=0x000 in the exact cycle of a wrap -> Ready remains 1, Overrun remains 0. Next wrap with no write -> Overrun=1.
- Write TCNT=0xFFFFFFFE with TLIM=0, CLKDIV=1 -> reads 0xFFFFFFFF, then 0x00000000; Ready and Overrun stay 0.
- Assert reset asynchronously mid-count with Ready=1 -> all registers read 0, irq drops before the next clk edge. Read of 0xFFFFF10C -> sel=0, rd_data=0.
